test_data_gen: RTL

//  Parametrised NRZ test-bit source feeding the HDB3 encoder. Supports a fixed or

---
 rtl/test_data_gen.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/test_data_gen.sv
// -----------------------------------------------------------------------------
// test_data_gen
//   NRZ test-bit source for the HDB3 encoder. Produces one bit per en strobe
//   from a cyclic pattern (fixed or user-loaded), PRBS7, PRBS15, constant 0/1
//   or an alternating 1/0 sequence. Flags the first bit of each sequence period
//   and can invert a single emitted bit on request for BER/link testing.
//
// Ports
//   clk         in   1      clock
//   rst_n       in   1      asynchronous active-low reset
//   en          in   1      bit strobe; one bit is emitted per cycle with en=1
//   load        in   1      latch mode/pat_in and restart the sequence (beats en)
//   mode        in   3      0 FIXED, 1 USER, 2 PRBS7, 3 PRBS15, 4 ZERO, 5 ONE,
//                           6 ALT, 7 ZERO
//   pat_in      in   PAT_W  user pattern, sampled on load
//   err_inject  in   1      request to invert the next emitted bit
//   data_out    out  1      registered NRZ bit, held between strobes
//   data_valid  out  1      high for one cycle after each emitted bit
//   seq_start   out  1      high with data_valid on the first bit of a period
// -----------------------------------------------------------------------------
module test_data_gen #(
    parameter int               PAT_W     = 32,
    parameter logic [PAT_W-1:0] PAT_INIT  = 32'hB00C_200B,
    parameter logic [14:0]      PRBS_SEED = 15'h7FFF,
    parameter logic [2:0]       MODE_RST  = 3'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [2:0]       mode,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             err_inject,
    output logic             data_out,
    output logic             data_valid,
    output logic             seq_start
);

    localparam logic [2:0] M_FIXED  = 3'd0;
    localparam logic [2:0] M_USER   = 3'd1;
    localparam logic [2:0] M_PRBS7  = 3'd2;
    localparam logic [2:0] M_PRBS15 = 3'd3;
    localparam logic [2:0] M_ONE    = 3'd5;
    localparam logic [2:0] M_ALT    = 3'd6;

    // Reload values used when the active LFSR has locked up at all-zero; a
    // zero seed (or zero low 7 bits for PRBS7) would lock up again, so force 1.
    localparam logic [14:0] SEED15_RELOAD = (PRBS_SEED == 15'd0) ? 15'd1 : PRBS_SEED;
    localparam logic [14:0] SEED7_RELOAD  = (PRBS_SEED[6:0] == 7'd0) ?
                                            {PRBS_SEED[14:7], 7'd1} : PRBS_SEED;

    logic [2:0]       mode_q,       mode_d;
    logic [PAT_W-1:0] shreg_q,      shreg_d;
    logic [14:0]      lfsr_q,       lfsr_d;
    logic [14:0]      pos_q,        pos_d;
    logic             alt_q,        alt_d;
    logic             err_pend_q,   err_pend_d;
    logic             data_out_q,   data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             seq_start_q,  seq_start_d;

    logic             bit_raw;
    logic [14:0]      pos_last;

    // Uncorrupted bit for the current position and last index of the period.
    always_comb begin
        bit_raw  = 1'b0;
        pos_last = 15'(PAT_W - 1);
        case (mode_q)
            M_FIXED, M_USER: bit_raw = shreg_q[PAT_W-1];
            M_PRBS7: begin
                bit_raw  = lfsr_q[6];
                pos_last = 15'd126;
            end
            M_PRBS15: begin
                bit_raw  = lfsr_q[14];
                pos_last = 15'd32766;
            end
            M_ONE:   bit_raw = 1'b1;
            M_ALT:   bit_raw = ~alt_q;
            default: bit_raw = 1'b0;
        endcase
    end

    always_comb begin
        mode_d       = mode_q;
        shreg_d      = shreg_q;
        lfsr_d       = lfsr_q;
        pos_d        = pos_q;
        alt_d        = alt_q;
        err_pend_d   = err_pend_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        seq_start_d  = 1'b0;

        if (load) begin
            mode_d     = mode;
            shreg_d    = (mode == M_USER) ? pat_in : PAT_INIT;
            lfsr_d     = PRBS_SEED;
            pos_d      = 15'd0;
            alt_d      = 1'b0;
            // A request arriving with load still has to wait for the next bit.
            err_pend_d = err_pend_q | err_inject;
        end else if (en) begin
            // Injection only touches the output bit, never the generator state.
            data_out_d   = bit_raw ^ (err_pend_q | err_inject);
            err_pend_d   = 1'b0;
            data_valid_d = 1'b1;
            seq_start_d  = (pos_q == 15'd0);
            pos_d        = (pos_q == pos_last) ? 15'd0 : pos_q + 15'd1;

            case (mode_q)
                M_FIXED, M_USER: shreg_d = {shreg_q[PAT_W-2:0], shreg_q[PAT_W-1]};
                M_PRBS7: begin
                    if (lfsr_q[6:0] == 7'd0)
                        lfsr_d = SEED7_RELOAD;
                    else
                        lfsr_d = {lfsr_q[14:7], lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
                end
                M_PRBS15: begin
                    if (lfsr_q == 15'd0)
                        lfsr_d = SEED15_RELOAD;
                    else
                        lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
                end
                M_ALT:   alt_d = ~alt_q;
                default: ;
            endcase
        end else if (err_inject) begin
            err_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= MODE_RST;
            shreg_q      <= PAT_INIT;
            lfsr_q       <= PRBS_SEED;
            pos_q        <= 15'd0;
            alt_q        <= 1'b0;
            err_pend_q   <= 1'b0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            seq_start_q  <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            shreg_q      <= shreg_d;
            lfsr_q       <= lfsr_d;
            pos_q        <= pos_d;
            alt_q        <= alt_d;
            err_pend_q   <= err_pend_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            seq_start_q  <= seq_start_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign seq_start  = seq_start_q;

endmodule
